rr_stream_mux: RTL and testbench
================================

// Module: rr_stream_mux
// PURPOSE
//  Parametrised N:1 stream multiplexer with a registered output stage and valid/ready handshake.
//  Generalises the 8-bit 4:1 datapath mux: any width and channel count, plus a round-robin arbitration mode.
//  Sits between multi-source producers (register-file read ports, memory data, ALU result) and a single
//  consumer in the multicycle datapath. Also serves as the shared-bus arbiter for later multi-master memory access.
// PARAMETERS
//  WIDTH  8  data width per channel, >=1
//  N      4  number of input channels, >=2
//  MODE   0  0 = FIXED (sel input chooses channel), 1 = RR (round-robin over in_valid)
//  SELW   $clog2(N)  channel index width (derived; do not override)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N        per-channel valid
//  in_ready   out  N        per-channel ready (combinational)
//  sel        in   SELW     channel select, used only when MODE=0
//  out_data   out  WIDTH    registered output data
//  out_chan   out  SELW     index of the channel that supplied out_data
//  out_valid  out  1        output word present
//  out_ready  in   1        consumer accepts output
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, rr_ptr=0. in_ready is 0 while rst_n=0.
//  - load_en = !out_valid | out_ready. A transfer on channel i occurs when in_valid[i] & in_ready[i].
//  - in_ready[i] = load_en & grant[i]; at most one grant bit is set per cycle.
//  - FIXED: grant = onehot(sel) & in_valid. sel >= N grants nothing. sel changes take effect the same cycle.
//  - RR: grant goes to the first valid channel scanning rr_ptr, rr_ptr+1, ... N-1, 0, ... (wrap).
//    On a transfer from channel g: rr_ptr <= (g+1) mod N. With no transfer, rr_ptr holds.
//  - Transfer at edge k: out_data=in_data[g], out_chan=g, out_valid=1 after edge k (latency 1 cycle).
//  - No transfer and out_ready=1: out_valid<=0; out_data/out_chan hold their last values.
//  - Stall (out_valid=1, out_ready=0): out_data, out_chan and out_valid stay stable; all in_ready=0.
//  - Simultaneous drain and load in one cycle is legal: sustained throughput is 1 word/cycle.
//  - Non-granted valid inputs must hold; the block never drops or duplicates an accepted word.
//  - Reset mid-operation: a pending output word is discarded and rr_ptr returns to 0.
//  - N not a power of 2: rr_ptr wraps at N-1 -> 0, never reaching indices >= N.
// STRUCTURE
//  - Package stream_mux_pkg: MODE_FIXED=0 and MODE_RR=1 constants, plus the clog2 helper used for SELW.
//  - Sub-module rr_arbiter (N): inputs req[N] and ptr; outputs grant[N] (one-hot) and gidx.
//    It is purely combinational; rr_ptr lives in the parent.
//  - Parent holds the output register, the rr_ptr register, the load_en logic and the FIXED-mode decode.
// TESTING
//  1 Reset: hold rst_n=0 with random inputs -> out_valid=0, out_data=0, out_chan=0, in_ready=0.
//  2 FIXED, N=4, W=8: sel=2, in_valid=4'b1111, ch2=8'hA5, out_ready=1 -> next cycle out_data=A5, out_chan=2,
//    in_ready=4'b0100. Then sel=3'd? is not legal at N=4; test sel>=N with N=5, sel=5 -> in_ready=0.
//  3 RR fairness: in_valid=4'b1111 constantly, out_ready=1 -> out_chan sequence 0,1,2,3,0,... at 1 word/cycle.
//  4 RR skip and wrap: rr_ptr=3, in_valid=4'b0010 -> grant ch1, out_chan=1. Next rr_ptr=2.
//    With N=3 and in_valid all set: 0,1,2,0 order, no index 3 produced.
//  5 Backpressure: out_ready=0 for 5 cycles after a load -> out_data/out_chan stable and in_ready=0.
//    On release: the held word is consumed and the next word loads in the same cycle.
//  6 Reset mid-stall: assert rst_n=0 while out_valid=1 -> out_valid drops immediately.
//    After release, RR restarts at channel 0.

Source files
------------

// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer.
package stream_mux_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   // Ceiling log2. Used to derive the channel index width.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// Stream bundle between N producers, the multiplexer and one consumer.
interface rr_stream_mux_if #(
   parameter int WIDTH = 8,
   parameter int N     = 4
);
   localparam int SELW = stream_mux_pkg::clog2(N);

   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [SELW-1:0]    sel;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_chan;
   logic               out_valid;
   logic               out_ready;

   modport slave (
      input  in_data, in_valid, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );

   modport master (
      output in_data, in_valid, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

endinterface

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping to 0.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int N    = 4,
   parameter int SELW = clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] gidx
);

   logic found;

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      // Upper pass covers ptr..N-1; if empty, the lower pass picks the lowest index, i.e. the wrap.
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (SELW'(i) >= ptr)) begin
            grant[i] = 1'b1;
            gidx     = SELW'(i);
            found    = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            grant[i] = 1'b1;
            gidx     = SELW'(i);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 stream multiplexer with registered output, fixed-select or round-robin arbitration.
module rr_stream_mux
   import stream_mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int MODE  = MODE_FIXED,
   parameter int SELW  = clog2(N)
) (
   input logic             clk,
   input logic             rst_n,
   rr_stream_mux_if.slave  io
);

   logic [N-1:0]     fixed_grant;
   logic [N-1:0]     rr_grant;
   logic [N-1:0]     grant;
   logic [N-1:0]     ready;
   logic [SELW-1:0]  rr_gidx;
   logic [SELW-1:0]  gidx;
   logic [WIDTH-1:0] grant_data;
   logic             load_en;
   logic             xfer;

   logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  out_chan_q,  out_chan_d;
   logic             out_valid_q, out_valid_d;

   rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
      .req   (io.in_valid),
      .ptr   (rr_ptr_q),
      .grant (rr_grant),
      .gidx  (rr_gidx)
   );

   // An out-of-range sel matches no channel and so grants nothing.
   always_comb begin
      fixed_grant = '0;
      for (int i = 0; i < N; i++) begin
         fixed_grant[i] = (io.sel == SELW'(i)) && io.in_valid[i];
      end
   end

   always_comb begin
      grant      = (MODE == MODE_RR) ? rr_grant : fixed_grant;
      gidx       = (MODE == MODE_RR) ? rr_gidx  : io.sel;
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) grant_data = io.in_data[i*WIDTH +: WIDTH];
      end
   end

   // The output register accepts a word when empty or draining; rst_n gates ready during reset.
   assign load_en = !out_valid_q || io.out_ready;
   assign ready   = grant & {N{load_en && rst_n}};
   assign xfer    = |ready;

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      if (xfer) begin
         out_data_d  = grant_data;
         out_chan_d  = gidx;
         out_valid_d = 1'b1;
         rr_ptr_d    = (gidx == SELW'(N - 1)) ? '0 : gidx + 1'b1;
      end else if (io.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign io.in_ready  = ready;
   assign io.out_data  = out_data_q;
   assign io.out_chan  = out_chan_q;
   assign io.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench: fixed-mode vector table, round-robin scoreboard, and hand-written corner sequences.
module tb_rr_stream_mux;
   import stream_mux_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   rr_stream_mux_if #(.WIDTH(8), .N(4)) f4_if ();
   rr_stream_mux_if #(.WIDTH(8), .N(5)) f5_if ();
   rr_stream_mux_if #(.WIDTH(8), .N(4)) r4_if ();
   rr_stream_mux_if #(.WIDTH(8), .N(3)) r3_if ();

   rr_stream_mux #(.WIDTH(8), .N(4), .MODE(MODE_FIXED)) u_f4 (.clk(clk), .rst_n(rst_n), .io(f4_if.slave));
   rr_stream_mux #(.WIDTH(8), .N(5), .MODE(MODE_FIXED)) u_f5 (.clk(clk), .rst_n(rst_n), .io(f5_if.slave));
   rr_stream_mux #(.WIDTH(8), .N(4), .MODE(MODE_RR))    u_r4 (.clk(clk), .rst_n(rst_n), .io(r4_if.slave));
   rr_stream_mux #(.WIDTH(8), .N(3), .MODE(MODE_RR))    u_r3 (.clk(clk), .rst_n(rst_n), .io(r3_if.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic idle_all();
      f4_if.in_data = '0; f4_if.in_valid = '0; f4_if.sel = '0; f4_if.out_ready = 1'b1;
      f5_if.in_data = '0; f5_if.in_valid = '0; f5_if.sel = '0; f5_if.out_ready = 1'b1;
      r4_if.in_data = '0; r4_if.in_valid = '0; r4_if.sel = '0; r4_if.out_ready = 1'b1;
      r3_if.in_data = '0; r3_if.in_valid = '0; r3_if.sel = '0; r3_if.out_ready = 1'b1;
   endtask

   task automatic randomize_all();
      f4_if.in_data = $urandom; f4_if.in_valid = 4'($urandom); f4_if.sel = 2'($urandom); f4_if.out_ready = 1'($urandom);
      f5_if.in_data = {8'($urandom), 32'($urandom)}; f5_if.in_valid = 5'($urandom);
      f5_if.sel = 3'($urandom); f5_if.out_ready = 1'($urandom);
      r4_if.in_data = $urandom; r4_if.in_valid = 4'($urandom); r4_if.out_ready = 1'($urandom);
      r3_if.in_data = 24'($urandom); r3_if.in_valid = 3'($urandom); r3_if.out_ready = 1'($urandom);
   endtask

   // Reference model and scoreboard for the N=4 round-robin instance.
   typedef struct {
      logic [7:0] d;
      logic [1:0] c;
   } word_t;

   word_t sbq[$];
   int    m_ptr;
   bit    m_valid;

   task automatic rr_cycle(input logic [3:0] valid, input logic ordy);
      logic [31:0] data;
      logic [3:0]  exp_rdy;
      int          g;
      word_t       w;
      data = $urandom;
      r4_if.in_valid  = valid;
      r4_if.in_data   = data;
      r4_if.out_ready = ordy;
      #1;
      g = -1;
      if (!m_valid || ordy) begin
         for (int k = 0; k < 4; k++) begin
            if (g < 0 && valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
         end
      end
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      check("r4 in_ready", 32'(r4_if.in_ready), 32'(exp_rdy));
      check("r4 out_valid", 32'(r4_if.out_valid), 32'(m_valid));
      if (m_valid) begin
         check("r4 out_data", 32'(r4_if.out_data), 32'(sbq[0].d));
         check("r4 out_chan", 32'(r4_if.out_chan), 32'(sbq[0].c));
         if (ordy) void'(sbq.pop_front());
      end
      if (g >= 0) begin
         w.d = data[g*8 +: 8];
         w.c = 2'(g);
         sbq.push_back(w);
         m_ptr   = (g + 1) % 4;
         m_valid = 1'b1;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic [3:0]  valid;
      logic [31:0] data;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [7:0]  exp_od;
      logic [1:0]  exp_oc;
   } fvec_t;

   fvec_t fvec[7];
   int    exp_seq[4];

   initial begin
      n_checks = 0;
      n_pass   = 0;
      m_ptr    = 0;
      m_valid  = 1'b0;

      // Each row: drive inputs, check combinational ready, then check registered outputs one edge later.
      fvec[0] = '{2'd2, 4'b1111, 32'h33A51100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
      fvec[1] = '{2'd0, 4'b1111, 32'h33A51100, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0};
      fvec[2] = '{2'd1, 4'b1101, 32'h33A51100, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
      fvec[3] = '{2'd3, 4'b1000, 32'h77665544, 1'b0, 4'b1000, 1'b1, 8'h77, 2'd3};
      fvec[4] = '{2'd1, 4'b1111, 32'h77665544, 1'b0, 4'b0000, 1'b1, 8'h77, 2'd3};
      fvec[5] = '{2'd1, 4'b1111, 32'h77665544, 1'b1, 4'b0010, 1'b1, 8'h55, 2'd1};
      fvec[6] = '{2'd2, 4'b0000, 32'h77665544, 1'b1, 4'b0000, 1'b0, 8'h55, 2'd1};
      exp_seq = '{0, 1, 2, 0};

      // Reset with random inputs.
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         randomize_all();
         #1;
         check("rst f4 out_valid", 32'(f4_if.out_valid), 32'h0);
         check("rst f4 out_data", 32'(f4_if.out_data), 32'h0);
         check("rst f4 out_chan", 32'(f4_if.out_chan), 32'h0);
         check("rst f4 in_ready", 32'(f4_if.in_ready), 32'h0);
         check("rst r4 in_ready", 32'(r4_if.in_ready), 32'h0);
         check("rst r4 out_valid", 32'(r4_if.out_valid), 32'h0);
      end
      @(negedge clk);
      idle_all();
      rst_n = 1'b1;
      @(negedge clk);

      // Fixed mode, N=4.
      for (int i = 0; i < 7; i++) begin
         f4_if.sel       = fvec[i].sel;
         f4_if.in_valid  = fvec[i].valid;
         f4_if.in_data   = fvec[i].data;
         f4_if.out_ready = fvec[i].ordy;
         #1;
         check($sformatf("f4 row%0d in_ready", i), 32'(f4_if.in_ready), 32'(fvec[i].exp_rdy));
         @(negedge clk);
         check($sformatf("f4 row%0d out_valid", i), 32'(f4_if.out_valid), 32'(fvec[i].exp_ov));
         check($sformatf("f4 row%0d out_data", i), 32'(f4_if.out_data), 32'(fvec[i].exp_od));
         check($sformatf("f4 row%0d out_chan", i), 32'(f4_if.out_chan), 32'(fvec[i].exp_oc));
      end

      // Fixed mode, N=5: sel beyond the last channel grants nothing.
      f5_if.sel       = 3'd5;
      f5_if.in_valid  = 5'b11111;
      f5_if.in_data   = 40'h44_33_22_11_00;
      f5_if.out_ready = 1'b1;
      #1;
      check("f5 sel5 in_ready", 32'(f5_if.in_ready), 32'h0);
      @(negedge clk);
      check("f5 sel5 out_valid", 32'(f5_if.out_valid), 32'h0);
      f5_if.sel = 3'd4;
      #1;
      check("f5 sel4 in_ready", 32'(f5_if.in_ready), 32'h10);
      @(negedge clk);
      check("f5 sel4 out_valid", 32'(f5_if.out_valid), 32'h1);
      check("f5 sel4 out_data", 32'(f5_if.out_data), 32'h44);
      check("f5 sel4 out_chan", 32'(f5_if.out_chan), 32'h4);
      f5_if.in_valid = '0;

      // Round robin, N=3: order 0,1,2,0 with no index 3.
      r3_if.in_valid  = 3'b111;
      r3_if.in_data   = 24'hC2C1C0;
      r3_if.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("r3 seq%0d out_chan", k), 32'(r3_if.out_chan), 32'(exp_seq[k]));
         check($sformatf("r3 seq%0d out_data", k), 32'(r3_if.out_data), 32'(8'hC0 + 8'(exp_seq[k])));
         check($sformatf("r3 seq%0d out_valid", k), 32'(r3_if.out_valid), 32'h1);
      end
      r3_if.in_valid = '0;
      @(negedge clk);

      // Round robin, N=4: fairness at full throughput.
      for (int k = 0; k < 8; k++) rr_cycle(4'b1111, 1'b1);
      // Skip and wrap: ch2 moves ptr to 3, then lone ch1 wins and ptr becomes 2.
      rr_cycle(4'b0100, 1'b1);
      rr_cycle(4'b0010, 1'b1);
      rr_cycle(4'b1111, 1'b1);
      // Backpressure for five cycles, then drain and load together.
      rr_cycle(4'b1111, 1'b1);
      for (int k = 0; k < 5; k++) rr_cycle(4'b1111, 1'b0);
      rr_cycle(4'b1111, 1'b1);
      rr_cycle(4'b0000, 1'b1);
      // Random traffic.
      for (int k = 0; k < 40; k++) rr_cycle(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      rr_cycle(4'b0000, 1'b1);
      rr_cycle(4'b0000, 1'b1);
      check("r4 scoreboard drained", 32'(sbq.size()), 32'h0);

      // Reset during a stall, with ptr left at 2.
      rr_cycle(4'b0010, 1'b1);
      rr_cycle(4'b1111, 1'b0);
      r4_if.in_valid = 4'b1111;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst r4 out_valid", 32'(r4_if.out_valid), 32'h0);
      check("midrst r4 in_ready", 32'(r4_if.in_ready), 32'h0);
      sbq.delete();
      m_ptr   = 0;
      m_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rr_cycle(4'b1111, 1'b1);
      rr_cycle(4'b0000, 1'b1);
      rr_cycle(4'b0000, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
